// File: rtl/msg_sender_pkg.sv
// Shared definitions for the message sender: sequencer states, ASCII helpers
// and the baud divider calculation.
package msg_sender_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic logic [23:0] clocks_per_baud(input int unsigned clk_hz,
                                                    input int unsigned baud);
        return 24'(clk_hz / baud);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/msg_sender_txuart.sv
// Minimal 8N1 transmitter. No reset: a frame already on the wire always runs
// to its stop bit; the all-zero power-up state is idle with the line high.
module txuart #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
    input  logic       i_clk,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_uart_tx,
    output logic       o_busy
);

    // bit_q: 0 idle, 1 start, 2..9 data LSB first, 10 stop
    logic [3:0]  bit_q, bit_d;
    logic [23:0] baud_q, baud_d;
    logic [7:0]  sh_q, sh_d;
    logic        line_n_q, line_n_d;

    always_comb begin
        bit_d    = bit_q;
        baud_d   = baud_q;
        sh_d     = sh_q;
        line_n_d = line_n_q;
        if (bit_q == 4'd0) begin
            if (i_wr) begin
                bit_d    = 4'd1;
                baud_d   = CLOCKS_PER_BAUD - 24'd1;
                sh_d     = i_data;
                line_n_d = 1'b1;
            end
        end else if (baud_q != 24'd0) begin
            baud_d = baud_q - 24'd1;
        end else begin
            baud_d = CLOCKS_PER_BAUD - 24'd1;
            if (bit_q == 4'd10) begin
                bit_d    = 4'd0;
                line_n_d = 1'b0;
            end else begin
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'd9) begin
                    line_n_d = 1'b0;
                end else begin
                    line_n_d = ~sh_q[0];
                    sh_d     = {1'b0, sh_q[7:1]};
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        bit_q    <= bit_d;
        baud_q   <= baud_d;
        sh_q     <= sh_d;
        line_n_q <= line_n_d;
    end

    assign o_uart_tx = ~line_n_q;
    assign o_busy    = (bit_q != 4'd0);

endmodule

// File: rtl/msg_sender.sv
// Sends a fixed string over txuart, started by a period timer or a trigger.
// One start request can be queued while a message is in progress.
module msg_sender
    import msg_sender_pkg::*;
#(
    parameter int unsigned          CLOCK_RATE_HZ = 100_000_000,
    parameter int unsigned          BAUD_RATE     = 115_200,
    parameter int                   MSG_LEN       = 15,
    parameter logic [8*MSG_LEN-1:0] MSG           = {"Hello, World!", ASCII_CR, ASCII_LF},
    parameter int unsigned          PERIOD_CLKS   = CLOCK_RATE_HZ,
    localparam int                  IW            = idx_width(MSG_LEN)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_enable,
    input  logic          i_trigger,
    output logic          o_uart_tx,
    output logic          o_busy,
    output logic          o_done,
    output logic [IW-1:0] o_index
);

    localparam logic [23:0]   CPB    = clocks_per_baud(CLOCK_RATE_HZ, BAUD_RATE);
    localparam int            TW     = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
    localparam logic [TW-1:0] RELOAD = TW'((PERIOD_CLKS == 0) ? 0 : PERIOD_CLKS - 1);
    localparam logic [IW-1:0] LAST   = IW'(MSG_LEN - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] index_q, index_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    data_q, data_d;
    logic          stb_q, stb_d;
    logic          done_q, done_d;
    logic          pending_q, pending_d;
    logic          tick, accept, tx_busy;

    always_comb begin
        tmr_d = tmr_q;
        tick  = 1'b0;
        if (i_enable && PERIOD_CLKS != 0) begin
            if (tmr_q == '0) begin
                tmr_d = RELOAD;
                tick  = 1'b1;
            end else begin
                tmr_d = tmr_q - 1'b1;
            end
        end
    end

    assign accept = stb_q && !tx_busy;

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        data_d    = data_q;
        stb_d     = stb_q;
        done_d    = 1'b0;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                // Holding off until the line is free keeps a frame that
                // survived a reset from being overwritten.
                if (pending_q && !tx_busy) begin
                    state_d   = ST_FETCH;
                    pending_d = 1'b0;
                end
            end
            ST_FETCH: begin
                data_d  = MSG[8*(MSG_LEN-1-int'(index_q)) +: 8];
                stb_d   = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (accept) begin
                    stb_d = 1'b0;
                    if (index_q == LAST) begin
                        index_d = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A request arriving as IDLE consumes the previous one stays queued.
        if (tick || i_trigger) pending_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            tmr_q     <= RELOAD;
            data_q    <= 8'h00;
            stb_q     <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            tmr_q     <= tmr_d;
            data_q    <= data_d;
            stb_q     <= stb_d;
            done_q    <= done_d;
            pending_q <= pending_d;
        end
    end

    txuart #(.CLOCKS_PER_BAUD(CPB)) u_tx (
        .i_clk    (i_clk),
        .i_wr     (stb_q),
        .i_data   (data_q),
        .o_uart_tx(o_uart_tx),
        .o_busy   (tx_busy)
    );

    assign o_busy  = (state_q != ST_IDLE);
    assign o_done  = done_q;
    assign o_index = index_q;

`ifdef FORMAL
    logic f_past_q = 1'b0;
    always @(posedge i_clk) begin
        f_past_q <= 1'b1;
        if (f_past_q && $past(i_reset_n)) begin
            if ($past(stb_q && tx_busy)) assert (data_q == $past(data_q));
            if (index_q != $past(index_q)) assert ($past(accept));
        end
        assert (index_q <= LAST);
        assert (!o_busy || state_q != ST_IDLE);
    end
`endif

endmodule

// File: tb/tb_msg_sender.sv
// Randomised bench for msg_sender: decodes both serial lines and compares the
// byte stream, message counts and start spacing against the expected behaviour.
module tb_msg_sender;

    localparam logic [7:0] MSG_A [3] = '{8'h48, 8'h69, 8'h0A};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, en = 1'b0, trig_a = 1'b0, trig_b = 1'b0;
    logic [1:0] tx, busy, done;
    logic [1:0] idx_a;
    logic [0:0] idx_b;

    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    msg_sender #(.CLOCK_RATE_HZ(800), .BAUD_RATE(100), .MSG_LEN(3),
                 .MSG(24'h48690A), .PERIOD_CLKS(400)) u_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_trigger(trig_a),
        .o_uart_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]), .o_index(idx_a));

    msg_sender #(.CLOCK_RATE_HZ(800), .BAUD_RATE(100), .MSG_LEN(1),
                 .MSG(8'h41), .PERIOD_CLKS(0)) u_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_trigger(trig_b),
        .o_uart_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]), .o_index(idx_b));

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Line decoder: 8 clocks per bit, sampled mid-bit.
    int         cyc;
    int         mcnt [2];
    int         ferr [2];
    int         ndone [2];
    int         badidx;
    bit         mact [2];
    bit         pbusy [2];
    bit [7:0]   msh [2];
    logic [7:0] rxq0 [$];
    logic [7:0] rxq1 [$];
    int         starts0 [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int u = 0; u < 2; u++) begin
            if (!mact[u]) begin
                if (!tx[u]) begin
                    mact[u] <= 1'b1;
                    mcnt[u] <= 1;
                    if (u == 0) starts0.push_back(cyc);
                end
            end else begin
                mcnt[u] <= mcnt[u] + 1;
                if (mcnt[u] == 4 && tx[u]) ferr[u] <= ferr[u] + 1;
                else if (mcnt[u] > 4 && mcnt[u] < 76 && mcnt[u] % 8 == 4)
                    msh[u] <= {tx[u], msh[u][7:1]};
                else if (mcnt[u] == 76) begin
                    mact[u] <= 1'b0;
                    if (!tx[u]) ferr[u] <= ferr[u] + 1;
                    if (u == 0) rxq0.push_back(msh[0]);
                    else rxq1.push_back(msh[1]);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (done[u]) begin
                ndone[u] <= ndone[u] + 1;
                chk("busy_low_at_done", 32'(busy[u]), 0);
                chk("busy_before_done", 32'(pbusy[u]), 1);
            end
            pbusy[u] <= busy[u];
        end
        if (idx_a > 2'd2 || idx_b != 1'b0) badidx <= badidx + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int which);
        @(posedge clk); #1;
        if (which == 0) trig_a = 1'b1; else trig_b = 1'b1;
        @(posedge clk); #1;
        trig_a = 1'b0;
        trig_b = 1'b0;
    endtask

    task automatic check_a(input string tag, input int base, input int nmsg);
        chk({tag, "_len"}, rxq0.size() - base, 3 * nmsg);
        for (int i = base; i < rxq0.size(); i++)
            chk(tag, 32'(rxq0[i]), 32'(MSG_A[(i - base) % 3]));
    endtask

    int base, dn, expm, sb, mg, d1;

    initial begin
        // reset state
        cycles(3);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_index", 32'(idx_a), 0);
        chk("rst_line_idle", 32'(tx), 3);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // period timer: three messages 400 clocks apart, then disabled
        base = rxq0.size(); dn = ndone[0]; sb = starts0.size();
        en = 1'b1;
        for (int k = 0; k < 3000 && starts0.size() < sb + 7; k++) cycles(1);
        en = 1'b0;
        chk("timer_wait", 32'(starts0.size() >= sb + 7), 1);
        cycles(800);
        check_a("timer_bytes", base, 3);
        chk("timer_done", ndone[0] - dn, 3);
        if (starts0.size() >= sb + 7) begin
            chk("timer_period1", starts0[sb + 3] - starts0[sb], 400);
            chk("timer_period2", starts0[sb + 6] - starts0[sb + 3], 400);
        end

        // random trigger rounds: an optional burst during a message queues one more
        for (int r = 0; r < 6; r++) begin
            base = rxq0.size(); dn = ndone[0]; expm = 1;
            pulse(0);
            if ($urandom_range(1, 0) == 1) begin
                cycles(int'($urandom_range(150, 10)));
                trig_a = 1'b1;
                cycles(int'($urandom_range(4, 1)));
                trig_a = 1'b0;
                expm = 2;
            end
            cycles(700);
            check_a("rand_bytes", base, expm);
            chk("rand_done", ndone[0] - dn, expm);
        end

        // held trigger mid-message gives one extra; a later trigger a third
        base = rxq0.size(); dn = ndone[0];
        pulse(0);
        cycles(60);
        trig_a = 1'b1; cycles(3); trig_a = 1'b0;
        cycles(300);
        pulse(0);
        cycles(900);
        check_a("queue_bytes", base, 3);
        chk("queue_done", ndone[0] - dn, 3);

        // reset during the second character
        base = rxq0.size(); dn = ndone[0]; sb = starts0.size();
        pulse(0);
        for (int k = 0; k < 500 && starts0.size() < sb + 2; k++) cycles(1);
        chk("rst_mid_wait", 32'(starts0.size() >= sb + 2), 1);
        cycles(20);
        rst_n = 1'b0; cycles(1); rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy[0]), 0);
        chk("rst_mid_index", 32'(idx_a), 0);
        cycles(300);
        chk("rst_mid_len", rxq0.size() - base, 2);
        if (rxq0.size() >= base + 2) begin
            chk("rst_mid_b0", 32'(rxq0[base]), 32'h48);
            chk("rst_mid_b1", 32'(rxq0[base + 1]), 32'h69);
        end
        pulse(0);
        cycles(400);
        check_a("rst_after", base + 2, 1);
        chk("rst_mid_done", ndone[0] - dn, 1);

        // single-character message
        base = rxq1.size(); dn = ndone[1];
        for (int r = 0; r < 3; r++) begin
            pulse(1);
            cycles(int'($urandom_range(260, 150)));
        end
        chk("one_len", rxq1.size() - base, 3);
        for (int i = base; i < rxq1.size(); i++) chk("one_byte", 32'(rxq1[i]), 32'h41);
        chk("one_done", ndone[1] - dn, 3);

        // trigger every cycle: back-to-back messages, at most one queued
        base = rxq0.size(); sb = starts0.size();
        @(posedge clk); #1;
        trig_a = 1'b1;
        cycles(700);
        trig_a = 1'b0;
        d1 = ndone[0];
        cycles(800);
        chk("cont_whole_msgs", (rxq0.size() - base) % 3, 0);
        chk("cont_enough", 32'((rxq0.size() - base) >= 6), 1);
        check_a("cont_bytes", base, (rxq0.size() - base) / 3);
        chk("cont_tail_msgs", 32'(ndone[0] - d1 >= 1 && ndone[0] - d1 <= 2), 1);
        mg = 0;
        for (int i = sb + 1; i < starts0.size(); i++)
            if (starts0[i] - starts0[i - 1] > mg) mg = starts0[i] - starts0[i - 1];
        chk("cont_gapless", 32'(mg >= 81 && mg <= 84), 1);

        chk("frame_err_a", ferr[0], 0);
        chk("frame_err_b", ferr[1], 0);
        chk("index_range", badidx, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
